serial_pattern_tx: RTL and testbench
====================================

// Module: serial_pattern_tx
// PURPOSE
//   Serial transmitter for fixed-width bit patterns, MSB first, one bit per clk.
//   Accepts a parallel word over a valid/ready handshake, or uses the PATTERN
//   constant. Drives the 1-bit x stream that the serial detectors consume.
//   Optional loop mode repeats the frame. Idle gap between frames is parameterised.
// PARAMETERS
//   WIDTH    12                 frame length in bits (>=2)
//   PATTERN  12'b1110_1101_1011 word sent when use_pat_i=1 at accept
//   GAP      2                  idle cycles after each frame (>=0)
// PORTS
//   clk        in   1      clock, all logic on posedge
//   reset      in   1      synchronous, active-high reset
//   valid_i    in   1      parallel word offered
//   data_i     in   WIDTH  word to send (ignored if use_pat_i=1)
//   use_pat_i  in   1      1: send PATTERN instead of data_i (sampled at accept)
//   loop_i     in   1      1: resend the held word after GAP without a new handshake
//   abort_i    in   1      synchronous abort of the frame in progress
//   ready_o    out  1      1 only in IDLE; accept = valid_i & ready_o at posedge
//   x_o        out  1      serial bit, registered
//   x_valid_o  out  1      1 while x_o carries a frame bit
//   busy_o     out  1      1 in SHIFT or GAP
//   done_o     out  1      1-cycle pulse coincident with the last bit (bit 0)
// BEHAVIOUR
//   - Reset (sync, active-high, highest priority): state=IDLE, shift reg=0,
//     counters=0, x_o=0, x_valid_o=0, busy_o=0, done_o=0, ready_o=1 next cycle.
//   - FSM states: IDLE, SHIFT, GAP.
//     IDLE : ready_o=1. On accept, load word (PATTERN or data_i) into shift reg
//            and a held copy, bit count=WIDTH-1, go to SHIFT.
//     SHIFT: x_o=shift[WIDTH-1], x_valid_o=1, shift left 1 per cycle, zero fill.
//            The cycle after accept carries the MSB; bit 0 appears WIDTH cycles after accept.
//            On the last bit, done_o=1. Next state is GAP if GAP>0.
//            If GAP=0 and loop_i=1, next state is SHIFT with the held word reloaded.
//            If GAP=0 and loop_i=0, next state is IDLE.
//     GAP  : x_o=0, x_valid_o=0, count GAP cycles. At the end, go to SHIFT with the
//            held word reloaded if loop_i=1, else go to IDLE.
//   - loop_i is sampled only at the frame-end decision point. Deasserting it mid-frame
//     completes that frame normally.
//   - Throughput:
//     non-loop: min accept-to-accept spacing = WIDTH+GAP+1 cycles (IDLE costs 1).
//     loop: frame period = WIDTH+GAP cycles; GAP=0 gives a gapless repeated stream.
//   - abort_i in SHIFT or GAP: next cycle state=IDLE, x_o=0, x_valid_o=0, no done_o.
//     abort_i in IDLE has no effect.
//     abort_i together with an accept in IDLE: the accept wins.
//   - reset together with any other input: reset wins.
//   - valid_i while busy: not accepted. The producer holds data_i stable until ready_o.
//   - Outputs are all registered; no combinational path from inputs to x_o,
//     x_valid_o or done_o.
//   - ready_o is decoded from state only.
// STRUCTURE
//   - Shared package: state encoding localparams (IDLE/SHIFT/GAP) and the default
//     12-bit PATTERN constant, so transmitter and detectors agree on one value.
//   - One natural sub-module: serial_pattern_tx_ctr (load/decrement/zero-flag counter,
//     width $clog2(max(WIDTH,GAP+1))). It is shared for the bit count and the gap count.
//   - Shift register, held word and FSM stay in the top module.
// TESTING
//   1. Reset mid-frame (after 5 bits) -> x_o=0, x_valid_o=0, busy_o=0; ready_o=1 the next cycle.
//   2. use_pat_i=1, GAP=2: accept at cycle 0 -> x_o = 1,1,1,0,1,1,0,1,1,0,1,1 on cycles
//      1-12; done_o=1 on cycle 12 only; x_valid_o=0 on cycles 13-14; ready_o=1 on cycle 15.
//   3. data_i=12'hA5C, offered back-to-back with valid_i held -> second accept on
//      cycle 15; bits MSB first, 1010_0101_1100.
//   4. loop_i=1, GAP=0, PATTERN -> continuous stream with period 12. A shift-register
//      match against 12'hEDB fires every 12 cycles. loop_i deasserted mid-frame ends the
//      stream after that frame; ready_o=1 the following cycle.
//   5. abort_i on the 7th bit -> next cycle idle with no done_o. A new accept with
//      data_i=12'hFFF then sends 12 ones.
//   6. valid_i asserted during SHIFT with data_i changing -> ignored. The frame in
//      flight is unchanged; the word is accepted only in IDLE.

Source files
------------

// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and the detectors that consume its stream.
package serial_pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [11:0] DEFAULT_PATTERN = 12'b1110_1101_1011;

endpackage

// File: rtl/serial_pattern_tx_ctr.sv
// Load/decrement down-counter with zero flag; reused for the bit count and the gap count.
module serial_pattern_tx_ctr #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [CW-1:0] i_val,
    input  logic          i_dec,
    output logic [CW-1:0] o_cnt,
    output logic          o_zero
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// MSB-first serial transmitter of a fixed-width word with optional looping and an idle gap between frames.
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int               WIDTH   = 12,
    parameter logic [WIDTH-1:0] PATTERN = WIDTH'(DEFAULT_PATTERN),
    parameter int               GAP     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             use_pat_i,
    input  logic             loop_i,
    input  logic             abort_i,
    output logic             ready_o,
    output logic             x_o,
    output logic             x_valid_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CMAX = (WIDTH > GAP + 1) ? WIDTH : GAP + 1;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] BITS_LD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'((GAP > 0) ? GAP - 1 : 0);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic [WIDTH-1:0] r_held, w_held_nxt;
    logic             r_xv, r_busy, r_done, w_done_nxt;
    logic             w_ld, w_dec, w_cnt_zero;
    logic [CW-1:0]    w_ld_val, w_cnt;
    logic [WIDTH-1:0] w_word;

    assign w_word = use_pat_i ? PATTERN : data_i;

    serial_pattern_tx_ctr #(.CW(CW)) u_ctr (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_ld),
        .i_val  (w_ld_val),
        .i_dec  (w_dec),
        .o_cnt  (w_cnt),
        .o_zero (w_cnt_zero)
    );

    // The shift register is zero outside a frame, so its MSB doubles as the registered x_o.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_held_nxt  = r_held;
        w_ld        = 1'b0;
        w_ld_val    = BITS_LD;
        w_dec       = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (valid_i) begin
                    w_shift_nxt = w_word;
                    w_held_nxt  = w_word;
                    w_ld        = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort_i) begin
                    w_shift_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else if (w_cnt_zero) begin
                    w_shift_nxt = r_shift << 1;
                    if (GAP > 0) begin
                        w_ld        = 1'b1;
                        w_ld_val    = GAP_LD;
                        w_state_nxt = ST_GAP;
                    end else if (loop_i) begin
                        w_shift_nxt = r_held;
                        w_ld        = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_shift_nxt = r_shift << 1;
                    w_dec       = 1'b1;
                    w_done_nxt  = (w_cnt == CW'(1));
                end
            end
            ST_GAP: begin
                if (abort_i) begin
                    w_shift_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else if (w_cnt_zero) begin
                    if (loop_i) begin
                        w_shift_nxt = r_held;
                        w_ld        = 1'b1;
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: begin
                w_shift_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_held  <= '0;
            r_xv    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_held  <= w_held_nxt;
            r_xv    <= (w_state_nxt == ST_SHIFT);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    assign ready_o   = (r_state == ST_IDLE);
    assign x_o       = r_shift[WIDTH-1];
    assign x_valid_o = r_xv;
    assign busy_o    = r_busy;
    assign done_o    = r_done;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench: instance A uses GAP=2, instance B uses GAP=0 for the gapless loop stream.
module tb_serial_pattern_tx;

    logic        clk = 1'b0;
    logic        reset, valid_a, valid_b, use_pat, loop_en, abort;
    logic [11:0] data;
    logic        ready_a, x_a, xv_a, busy_a, done_a;
    logic        ready_b, x_b, xv_b, busy_b, done_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(12), .PATTERN(12'hEDB), .GAP(2)) dut_a (
        .clk(clk), .reset(reset), .valid_i(valid_a), .data_i(data), .use_pat_i(use_pat),
        .loop_i(loop_en), .abort_i(abort), .ready_o(ready_a), .x_o(x_a),
        .x_valid_o(xv_a), .busy_o(busy_a), .done_o(done_a)
    );

    serial_pattern_tx #(.WIDTH(12), .PATTERN(12'hEDB), .GAP(0)) dut_b (
        .clk(clk), .reset(reset), .valid_i(valid_b), .data_i(data), .use_pat_i(use_pat),
        .loop_i(loop_en), .abort_i(abort), .ready_o(ready_b), .x_o(x_b),
        .x_valid_o(xv_b), .busy_o(busy_b), .done_o(done_b)
    );

    typedef struct {
        logic        up;
        logic [11:0] d;
        logic [11:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts on the first-bit cycle; leaves on the cycle after the last bit.
    task automatic collect(input logic scramble, output logic [11:0] w);
        w = '0;
        for (int k = 0; k < 12; k++) begin
            w = {w[10:0], x_a};
            if (scramble) data = 12'($urandom);
            step();
        end
    endtask

    task automatic send_frame(input logic up, input logic [11:0] d, input logic [11:0] exp,
                              input logic ab);
        int w = 0;
        while (!ready_a && w < 50) begin
            step();
            w++;
        end
        chk("ready_wait", ready_a, 1);
        valid_a = 1'b1; use_pat = up; data = d; abort = ab;
        step();
        valid_a = 1'b0; abort = 1'b0; data = ~d; use_pat = ~up;
        for (int k = 1; k <= 12; k++) begin
            chk("bit", x_a, exp[12-k]);
            chk("xvalid", xv_a, 1);
            chk("done", done_a, (k == 12));
            chk("ready_in_frame", ready_a, 0);
            step();
        end
        for (int g = 0; g < 2; g++) begin
            chk("gap_xvalid", xv_a, 0);
            chk("gap_x", x_a, 0);
            chk("gap_busy", busy_a, 1);
            step();
        end
        chk("ready_after", ready_a, 1);
        chk("busy_after", busy_a, 0);
    endtask

    initial begin
        vec_t        vecs[4];
        logic [11:0] w1, w2, sr;

        vecs[0] = '{up: 1'b1, d: 12'h000, exp: 12'hEDB};
        vecs[1] = '{up: 1'b0, d: 12'hA5C, exp: 12'hA5C};
        vecs[2] = '{up: 1'b1, d: 12'h123, exp: 12'hEDB};
        vecs[3] = '{up: 1'b0, d: 12'h801, exp: 12'h801};

        reset = 1'b1; valid_a = 0; valid_b = 0; use_pat = 0; loop_en = 0; abort = 0; data = '0;
        step(); step();
        chk("rst_x", x_a, 0);
        chk("rst_xv", xv_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_ready", ready_a, 1);
        chk("rst_ready_b", ready_b, 1);
        reset = 1'b0;
        step();

        for (int i = 0; i < 4; i++)
            send_frame(vecs[i].up, vecs[i].d, vecs[i].exp, 1'b0);

        // Reset after five bits.
        valid_a = 1'b1; data = 12'hFFF; use_pat = 1'b0;
        step();
        valid_a = 1'b0;
        repeat (4) step();
        chk("mid_xv_before_rst", xv_a, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_x", x_a, 0);
        chk("midrst_xv", xv_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_done", done_a, 0);
        chk("midrst_ready", ready_a, 1);
        step();

        // Back-to-back with valid held: second accept on cycle 15.
        valid_a = 1'b1; data = 12'hA5C;
        step();
        collect(1'b0, w1);
        chk("b2b_ready13", ready_a, 0);
        step();
        chk("b2b_ready14", ready_a, 0);
        step();
        chk("b2b_ready15", ready_a, 1);
        chk("b2b_word1", w1, 12'hA5C);
        step();
        valid_a = 1'b0;
        chk("b2b_xv16", xv_a, 1);
        collect(1'b0, w2);
        chk("b2b_word2", w2, 12'hA5C);
        step(); step();
        chk("b2b_idle", ready_a, 1);

        // valid_i with changing data during the frame is ignored.
        valid_a = 1'b1; data = 12'h3C6;
        step();
        collect(1'b1, w1);
        step();
        data = 12'h9E1;
        step();
        chk("busy_valid_word", w1, 12'h3C6);
        chk("busy_valid_ready15", ready_a, 1);
        step();
        valid_a = 1'b0;
        collect(1'b0, w2);
        chk("busy_valid_next", w2, 12'h9E1);
        step(); step();

        // Abort on the 7th bit, then accept-with-abort sends twelve ones.
        valid_a = 1'b1; data = 12'h5A5;
        step();
        valid_a = 1'b0;
        repeat (6) step();
        chk("abort_bit7", x_a, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_xv", xv_a, 0);
        chk("abort_x", x_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_ready", ready_a, 1);
        for (int k = 0; k < 6; k++) begin
            chk("abort_no_done", done_a, 0);
            step();
        end
        send_frame(1'b0, 12'hFFF, 12'hFFF, 1'b1);

        // Gapless loop on instance B; loop dropped mid fourth frame.
        loop_en = 1'b1; use_pat = 1'b1; valid_b = 1'b1;
        step();
        valid_b = 1'b0; use_pat = 1'b0;
        sr = '0;
        for (int k = 1; k <= 48; k++) begin
            sr = {sr[10:0], x_b};
            chk("loop_xv", xv_b, 1);
            chk("loop_done", done_b, (k % 12 == 0));
            chk("loop_match", (sr == 12'hEDB), (k % 12 == 0));
            if (k == 40) loop_en = 1'b0;
            step();
        end
        chk("loop_end_ready", ready_b, 1);
        chk("loop_end_xv", xv_b, 0);
        chk("loop_end_busy", busy_b, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
